fir_seq_ctrl: RTL and testbench



---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_fir_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and defaults for the time-multiplexed FIR sequencer.
package fir_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FIR_DEPTH  = 32;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WRITE,
    MAC,
    DRAIN,
    OUTPUT
  } state_t;

  // Modular decrement that also works for non-power-of-2 depths.
  function automatic int unsigned mod_dec(
    input int unsigned idx,
    input int unsigned depth
  );
    return (idx == 0) ? depth - 1 : idx - 1;
  endfunction

endpackage

// File: rtl/fir_seq_ctrl.sv
// FIR sequencer: delay-line zero fill, sample write, tap stepping,
// MAC drain and result handshake, all in one registered FSM.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int FIR_DEPTH   = DEF_FIR_DEPTH,
  parameter int MAC_LATENCY = 2,
  parameter int ADDR_WIDTH  = $clog2(FIR_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_sample_valid,
  output logic                  o_sample_ready,
  output logic                  o_wr_en,
  output logic                  o_wr_zero,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic [ADDR_WIDTH-1:0] o_coef_addr,
  output logic                  o_tap_valid,
  output logic                  o_acc_clr,
  output logic                  o_tap_last,
  output logic                  o_result_valid,
  input  logic                  i_result_ready
);

  localparam int CNT_MAX =
    (FIR_DEPTH > MAC_LATENCY) ? FIR_DEPTH : MAC_LATENCY;
  localparam int CNT_W = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] TAP_END = CNT_W'(FIR_DEPTH - 1);
  localparam logic [CNT_W-1:0] TAP_PEN = CNT_W'(FIR_DEPTH - 2);
  localparam logic [CNT_W-1:0] DRN_END = CNT_W'(MAC_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_END =
    ADDR_WIDTH'(FIR_DEPTH - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_WIDTH-1:0]   head;
  logic [ADDR_WIDTH-1:0]   newest;

  assign o_sample_ready = (state == IDLE) & i_en;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= INIT;
      cnt            <= '0;
      head           <= '0;
      newest         <= '0;
      o_wr_en        <= 1'b0;
      o_wr_zero      <= 1'b0;
      o_wr_addr      <= '0;
      o_rd_addr      <= '0;
      o_coef_addr    <= '0;
      o_tap_valid    <= 1'b0;
      o_acc_clr      <= 1'b0;
      o_tap_last     <= 1'b0;
      o_result_valid <= 1'b0;
    end else begin
      o_wr_en     <= 1'b0;
      o_wr_zero   <= 1'b0;
      o_tap_valid <= 1'b0;
      o_acc_clr   <= 1'b0;
      o_tap_last  <= 1'b0;
      unique case (state)
        INIT: begin
          // The reset cycle leaves o_wr_en low, which marks the first fill write.
          if (!o_wr_en) begin
            o_wr_en   <= 1'b1;
            o_wr_zero <= 1'b1;
            o_wr_addr <= '0;
          end else if (cnt == TAP_END) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt       <= cnt + CNT_W'(1);
            o_wr_en   <= 1'b1;
            o_wr_zero <= 1'b1;
            o_wr_addr <= o_wr_addr + ADDR_WIDTH'(1);
          end
        end
        IDLE: begin
          if (i_sample_valid && o_sample_ready) begin
            state     <= WRITE;
            cnt       <= '0;
            o_wr_en   <= 1'b1;
            o_wr_addr <= head;
            newest    <= head;
            head      <= (head == ADDR_END) ? '0 : head + ADDR_WIDTH'(1);
          end
        end
        WRITE: begin
          state       <= MAC;
          cnt         <= '0;
          o_tap_valid <= 1'b1;
          o_acc_clr   <= 1'b1;
          o_coef_addr <= '0;
          o_rd_addr   <= newest;
        end
        MAC: begin
          if (cnt == TAP_END) begin
            state <= DRAIN;
            cnt   <= '0;
          end else begin
            cnt         <= cnt + CNT_W'(1);
            o_tap_valid <= 1'b1;
            o_tap_last  <= (cnt == TAP_PEN);
            o_coef_addr <= o_coef_addr + ADDR_WIDTH'(1);
            o_rd_addr   <= ADDR_WIDTH'(
              mod_dec(32'(o_rd_addr), 32'(FIR_DEPTH)));
          end
        end
        DRAIN: begin
          if (cnt == DRN_END) begin
            state          <= OUTPUT;
            cnt            <= '0;
            o_result_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        OUTPUT: begin
          if (i_result_ready) begin
            state          <= IDLE;
            cnt            <= '0;
            o_result_valid <= 1'b0;
          end
        end
        default: begin
          state <= INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed self-checking bench for fir_seq_ctrl with default depth/latency.
module tb_fir_seq_ctrl;

  localparam int D = 32;
  localparam int L = 2;
  localparam int AW = 5;
  localparam int NV = 38;

  logic          tb_clk = 1'b0;
  logic          i_rst;
  logic          i_en;
  logic          i_sample_valid;
  logic          o_sample_ready;
  logic          o_wr_en;
  logic          o_wr_zero;
  logic [AW-1:0] o_wr_addr;
  logic [AW-1:0] o_rd_addr;
  logic [AW-1:0] o_coef_addr;
  logic          o_tap_valid;
  logic          o_acc_clr;
  logic          o_tap_last;
  logic          o_result_valid;
  logic          i_result_ready;

  int checks = 0;
  int errors = 0;

  always #5 tb_clk = ~tb_clk;

  fir_seq_ctrl #(
    .FIR_DEPTH  (D),
    .MAC_LATENCY(L)
  ) dut (
    .i_clk         (tb_clk),
    .i_rst         (i_rst),
    .i_en          (i_en),
    .i_sample_valid(i_sample_valid),
    .o_sample_ready(o_sample_ready),
    .o_wr_en       (o_wr_en),
    .o_wr_zero     (o_wr_zero),
    .o_wr_addr     (o_wr_addr),
    .o_rd_addr     (o_rd_addr),
    .o_coef_addr   (o_coef_addr),
    .o_tap_valid   (o_tap_valid),
    .o_acc_clr     (o_acc_clr),
    .o_tap_last    (o_tap_last),
    .o_result_valid(o_result_valid),
    .i_result_ready(i_result_ready)
  );

  typedef struct {
    int vld;
    int rdy;
    int wr;
    int zero;
    int waddr;
    int tap;
    int raddr;
    int caddr;
    int clr;
    int last;
    int rv;
  } vec_t;

  vec_t tbl [NV];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge tb_clk);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", int'(o_sample_ready), 0);
    chk("rst_wr_en", int'(o_wr_en), 0);
    chk("rst_wr_zero", int'(o_wr_zero), 0);
    chk("rst_wr_addr", int'(o_wr_addr), 0);
    chk("rst_tap_valid", int'(o_tap_valid), 0);
    chk("rst_acc_clr", int'(o_acc_clr), 0);
    chk("rst_tap_last", int'(o_tap_last), 0);
    chk("rst_result_valid", int'(o_result_valid), 0);
  endtask

  // Called right after i_rst is dropped at a negedge.
  task automatic init_check();
    for (int k = 0; k < D; k++) begin
      tick();
      #1;
      chk("init_wr_en", int'(o_wr_en), 1);
      chk("init_wr_zero", int'(o_wr_zero), 1);
      chk("init_wr_addr", int'(o_wr_addr), k);
      chk("init_ready", int'(o_sample_ready), 0);
      chk("init_tap_valid", int'(o_tap_valid), 0);
      chk("init_result_valid", int'(o_result_valid), 0);
    end
    tick();
    #1;
    chk("init_done_wr_en", int'(o_wr_en), 0);
    chk("init_done_ready", int'(o_sample_ready), 1);
  endtask

  // Starts at a negedge in IDLE; ends at the negedge of the next IDLE cycle.
  task automatic do_sample(input int a, input int hold, input int drop_en);
    i_sample_valid = 1'b1;
    i_result_ready = (hold == 0);
    #1;
    chk("accept_ready", int'(o_sample_ready), 1);
    tick();
    i_sample_valid = 1'b0;
    #1;
    chk("wr_en", int'(o_wr_en), 1);
    chk("wr_zero", int'(o_wr_zero), 0);
    chk("wr_addr", int'(o_wr_addr), a);
    chk("wr_no_tap", int'(o_tap_valid), 0);
    for (int k = 0; k < D; k++) begin
      tick();
      if (drop_en != 0 && k == 5) i_en = 1'b0;
      #1;
      chk("tap_valid", int'(o_tap_valid), 1);
      chk("tap_rd_addr", int'(o_rd_addr), (a - k + D) % D);
      chk("tap_coef_addr", int'(o_coef_addr), k);
      chk("tap_acc_clr", int'(o_acc_clr), int'(k == 0));
      chk("tap_last", int'(o_tap_last), int'(k == D - 1));
      chk("tap_wr_overlap", int'(o_wr_en), 0);
    end
    for (int d = 0; d < L; d++) begin
      tick();
      #1;
      chk("drain_tap_valid", int'(o_tap_valid), 0);
      chk("drain_result_valid", int'(o_result_valid), 0);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      i_sample_valid = 1'b1;
      #1;
      chk("hold_result_valid", int'(o_result_valid), 1);
      chk("hold_ready", int'(o_sample_ready), 0);
      chk("hold_no_write", int'(o_wr_en), 0);
    end
    tick();
    i_sample_valid = 1'b0;
    i_result_ready = 1'b1;
    #1;
    chk("result_valid", int'(o_result_valid), 1);
    chk("result_ready_blk", int'(o_sample_ready), 0);
    tick();
    i_en = 1'b1;
    #1;
    chk("post_result_valid", int'(o_result_valid), 0);
    chk("post_ready", int'(o_sample_ready), 1);
    chk("post_no_write", int'(o_wr_en), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NV; i++) begin
      tbl[i] = '{default: 0};
    end
    tbl[0].vld = 1;
    tbl[0].rdy = 1;
    tbl[1].wr = 1;
    tbl[1].waddr = 0;
    for (int k = 0; k < D; k++) begin
      tbl[2 + k].tap = 1;
      tbl[2 + k].raddr = (D - k) % D;
      tbl[2 + k].caddr = k;
      tbl[2 + k].clr = int'(k == 0);
      tbl[2 + k].last = int'(k == D - 1);
    end
    tbl[36].rv = 1;
    tbl[37].rdy = 1;

    i_rst = 1'b1;
    i_en = 1'b1;
    i_sample_valid = 1'b0;
    i_result_ready = 1'b1;
    repeat (3) tick();
    #1;
    chk_reset_vals();
    i_rst = 1'b0;
    init_check();

    // First sample after fill, cycle by cycle from the acceptance cycle.
    for (int i = 0; i < NV; i++) begin
      if (i > 0) tick();
      i_sample_valid = tbl[i].vld[0];
      #1;
      chk("v_ready", int'(o_sample_ready), tbl[i].rdy);
      chk("v_wr_en", int'(o_wr_en), tbl[i].wr);
      chk("v_wr_zero", int'(o_wr_zero), tbl[i].zero);
      if (tbl[i].wr != 0)
        chk("v_wr_addr", int'(o_wr_addr), tbl[i].waddr);
      chk("v_tap_valid", int'(o_tap_valid), tbl[i].tap);
      if (tbl[i].tap != 0) begin
        chk("v_rd_addr", int'(o_rd_addr), tbl[i].raddr);
        chk("v_coef_addr", int'(o_coef_addr), tbl[i].caddr);
      end
      chk("v_acc_clr", int'(o_acc_clr), tbl[i].clr);
      chk("v_tap_last", int'(o_tap_last), tbl[i].last);
      chk("v_result_valid", int'(o_result_valid), tbl[i].rv);
    end

    // Enable low in IDLE blocks acceptance.
    i_en = 1'b0;
    i_sample_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      #1;
      chk("en_low_ready", int'(o_sample_ready), 0);
      chk("en_low_no_write", int'(o_wr_en), 0);
    end
    i_sample_valid = 1'b0;
    i_en = 1'b1;
    #1;
    chk("en_high_ready", int'(o_sample_ready), 1);

    for (int s = 1; s < D; s++) begin
      do_sample(s, 0, 0);
    end
    do_sample(0, 0, 0);
    do_sample(1, 10, 0);
    do_sample(2, 0, 1);

    // Reset during tap 10 of the sample written at address 3.
    i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
    #1;
    chk("rst_seq_wr_addr", int'(o_wr_addr), 3);
    for (int k = 0; k <= 10; k++) tick();
    #1;
    chk("rst_seq_tap10_rd", int'(o_rd_addr), (3 - 10 + D) % D);
    chk("rst_seq_tap10_coef", int'(o_coef_addr), 10);
    i_rst = 1'b1;
    tick();
    #1;
    chk_reset_vals();
    i_rst = 1'b0;
    init_check();
    do_sample(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
